// File: rtl/toggle_edge_counter.sv
// toggle_edge_counter: synchronizes the blinker's toggle output, detects each
// rising edge and counts edges in two-digit BCD (00-99, wrapping). Drives
// registered seven-segment patterns, a per-edge pulse and a sticky wrap flag.
module toggle_edge_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       toggle,
  input  logic       enable,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       edge_pulse,
  output logic       wrapped
);

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  logic                   prev_q, prev_d;
  logic                   rise, cnt_ev;
  logic [3:0]             ones_q, ones_d;
  logic [3:0]             tens_q, tens_d;
  logic [6:0]             seg_ones_q, seg_ones_d;
  logic [6:0]             seg_tens_q, seg_tens_d;
  logic                   edge_pulse_q, edge_pulse_d;
  logic                   wrapped_q, wrapped_d;

  // Active-high segments a..g on bits 0..6; illegal digits blank the display.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q;
  assign cnt_ev = rise & enable & ~clear;

  // Synchronizer shift and edge history track toggle regardless of enable.
  always_comb begin
    sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], toggle};
    prev_d       = sync_q;
  end

  // Next count with clear taking priority; segments decoded from next digits
  // so the registered patterns always match the registered count.
  always_comb begin
    ones_d       = ones_q;
    tens_d       = tens_q;
    wrapped_d    = wrapped_q;
    edge_pulse_d = 1'b0;
    if (clear) begin
      ones_d    = 4'd0;
      tens_d    = 4'd0;
      wrapped_d = 1'b0;
    end else if (cnt_ev) begin
      edge_pulse_d = 1'b1;
      if (ones_q < 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else begin
        ones_d = 4'd0;
        if (tens_q < 4'd9) begin
          tens_d = tens_q + 4'd1;
        end else begin
          tens_d    = 4'd0;
          wrapped_d = 1'b1;
        end
      end
    end
    seg_ones_d = seg7(ones_d);
    seg_tens_d = seg7(tens_d);
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain_q <= '0;
      prev_q       <= 1'b0;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      seg_ones_q   <= 7'h3F;
      seg_tens_q   <= 7'h3F;
      edge_pulse_q <= 1'b0;
      wrapped_q    <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      prev_q       <= prev_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      seg_ones_q   <= seg_ones_d;
      seg_tens_q   <= seg_tens_d;
      edge_pulse_q <= edge_pulse_d;
      wrapped_q    <= wrapped_d;
    end
  end

  assign count_bcd  = {tens_q, ones_q};
  assign seg_tens   = seg_tens_q;
  assign seg_ones   = seg_ones_q;
  assign edge_pulse = edge_pulse_q;
  assign wrapped    = wrapped_q;

endmodule
